// File: rtl/dice_game_pkg.sv
// Shared types and helpers for the dice-race game logic.
// Colour codes are common to the detector, result manager and turn controller.
package dice_game_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_WAIT_COLOR = 3'd1,
        ST_MOVE       = 3'd2,
        ST_WAIT_CLEAR = 3'd3,
        ST_GAME_OVER  = 3'd4
    } game_state_t;

    localparam logic [1:0] COLOR_NONE  = 2'b00;
    localparam logic [1:0] COLOR_RED   = 2'b01;
    localparam logic [1:0] COLOR_GREEN = 2'b10;
    localparam logic [1:0] COLOR_BLUE  = 2'b11;

    localparam int STEPS_W = 8;

    function automatic logic [STEPS_W-1:0] steps_for_color(
        input logic [1:0]  color,
        input int unsigned red_steps,
        input int unsigned green_steps,
        input int unsigned blue_steps
    );
        logic [STEPS_W-1:0] s;
        s = '0;
        case (color)
            COLOR_RED:   s = STEPS_W'(red_steps);
            COLOR_GREEN: s = STEPS_W'(green_steps);
            COLOR_BLUE:  s = STEPS_W'(blue_steps);
            default:     s = '0;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/dice_turn_controller_step_timer.sv
// Paces a token move: one tick every STEP_TICKS cycles,
// done on the tick that consumes the last step.
module step_timer
    import dice_game_pkg::*;
#(
    parameter int unsigned STEP_TICKS = 12500000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               abort,
    input  logic [STEPS_W-1:0] steps,
    output logic               tick,
    output logic               done
);

    localparam int TICK_W = $clog2(STEP_TICKS + 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(STEP_TICKS - 1);

    logic [TICK_W-1:0]  tick_cnt_q, tick_cnt_d;
    logic [STEPS_W-1:0] steps_left_q, steps_left_d;
    logic               busy_q, busy_d;

    assign tick = busy_q && (tick_cnt_q == TICK_LAST);
    assign done = tick && (steps_left_q == STEPS_W'(1));

    // Load on start, count ticks while busy, drop out on the final step or abort.
    always_comb begin
        tick_cnt_d   = tick_cnt_q;
        steps_left_d = steps_left_q;
        busy_d       = busy_q;
        if (start) begin
            tick_cnt_d   = '0;
            steps_left_d = steps;
            busy_d       = (steps != '0);
        end else if (abort) begin
            tick_cnt_d   = '0;
            steps_left_d = '0;
            busy_d       = 1'b0;
        end else if (busy_q) begin
            if (tick) begin
                tick_cnt_d   = '0;
                steps_left_d = steps_left_q - STEPS_W'(1);
                if (done) begin
                    busy_d = 1'b0;
                end
            end else begin
                tick_cnt_d = tick_cnt_q + TICK_W'(1);
            end
        end
    end

    // Timer state registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tick_cnt_q   <= '0;
            steps_left_q <= '0;
            busy_q       <= 1'b0;
        end else begin
            tick_cnt_q   <= tick_cnt_d;
            steps_left_q <= steps_left_d;
            busy_q       <= busy_d;
        end
    end

endmodule

// File: rtl/dice_turn_controller.sv
// Turn sequencer for the dice race: accepts die colours, steps the
// active token cell by cell, rotates players and detects the winner.
module dice_turn_controller
    import dice_game_pkg::*;
#(
    parameter int unsigned NUM_PLAYERS   = 2,
    parameter int unsigned BOARD_LEN     = 20,
    parameter int unsigned POS_W         = 5,
    parameter int unsigned RED_STEPS     = 1,
    parameter int unsigned GREEN_STEPS   = 2,
    parameter int unsigned BLUE_STEPS    = 3,
    parameter int unsigned STEP_TICKS    = 12500000,
    parameter int unsigned TIMEOUT_TICKS = 0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic [1:0]                   detected_color,
    input  logic                         color_result_ready,
    input  logic                         turn_end,
    output logic [$clog2(NUM_PLAYERS)-1:0] cur_player,
    output logic [NUM_PLAYERS*POS_W-1:0] positions,
    output logic [2:0]                   state_o,
    output logic                         move_active,
    output logic                         turn_done,
    output logic [$clog2(NUM_PLAYERS)-1:0] winner,
    output logic                         game_over
);

    localparam int PL_W = $clog2(NUM_PLAYERS);
    localparam int POS_TOTAL = NUM_PLAYERS * POS_W;
    localparam logic [PL_W-1:0] LAST_PLAYER = PL_W'(NUM_PLAYERS - 1);
    localparam logic [POS_W-1:0] LAST_CELL = POS_W'(BOARD_LEN - 1);

    localparam bit TIMEOUT_EN = (TIMEOUT_TICKS != 0);
    localparam int WAIT_W = $clog2(TIMEOUT_TICKS + 2);
    localparam int unsigned WAIT_LAST_I =
        (TIMEOUT_TICKS == 0) ? 0 : TIMEOUT_TICKS - 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_LAST_I);

    game_state_t            state_q, state_d;
    logic [PL_W-1:0]        cur_player_q, cur_player_d;
    logic [POS_TOTAL-1:0]   positions_q, positions_d;
    logic [PL_W-1:0]        winner_q, winner_d;
    logic                   turn_done_q, turn_done_d;
    logic                   move_active_q, move_active_d;
    logic                   game_over_q, game_over_d;
    logic [WAIT_W-1:0]      wait_cnt_q, wait_cnt_d;

    logic                   timer_start;
    logic                   timer_abort;
    logic [STEPS_W-1:0]     timer_steps;
    logic                   step_tick;
    logic                   step_done;

    logic [POS_W-1:0]       cur_pos;
    logic [POS_W-1:0]       next_pos;
    logic [PL_W-1:0]        next_player;
    logic                   color_valid;
    int                     pos_base;

    step_timer #(
        .STEP_TICKS (STEP_TICKS)
    ) u_step_timer (
        .clk   (clk),
        .reset (reset),
        .start (timer_start),
        .abort (timer_abort),
        .steps (timer_steps),
        .tick  (step_tick),
        .done  (step_done)
    );

    // Active token position, its clamped successor and the next player.
    always_comb begin
        pos_base = int'(cur_player_q) * int'(POS_W);
        cur_pos  = positions_q[pos_base +: POS_W];
        if (cur_pos >= LAST_CELL) begin
            next_pos = LAST_CELL;
        end else begin
            next_pos = cur_pos + POS_W'(1);
        end
        if (cur_player_q == LAST_PLAYER) begin
            next_player = '0;
        end else begin
            next_player = cur_player_q + PL_W'(1);
        end
        color_valid = color_result_ready &&
                      (detected_color != COLOR_NONE);
        timer_steps = steps_for_color(detected_color, RED_STEPS,
                                      GREEN_STEPS, BLUE_STEPS);
    end

    // Game FSM: next state, positions, player rotation and timer control.
    always_comb begin
        state_d      = state_q;
        cur_player_d = cur_player_q;
        positions_d  = positions_q;
        winner_d     = winner_q;
        wait_cnt_d   = wait_cnt_q;
        turn_done_d  = 1'b0;
        timer_start  = 1'b0;
        timer_abort  = 1'b0;
        unique case (state_q)
            ST_IDLE, ST_GAME_OVER: begin
                if (start) begin
                    positions_d  = '0;
                    cur_player_d = '0;
                    winner_d     = '0;
                    wait_cnt_d   = '0;
                    state_d      = ST_WAIT_COLOR;
                end
            end
            ST_WAIT_COLOR: begin
                if (color_valid) begin
                    wait_cnt_d = '0;
                    if (timer_steps == '0) begin
                        state_d = ST_WAIT_CLEAR;
                    end else begin
                        timer_start = 1'b1;
                        state_d     = ST_MOVE;
                    end
                end else if (TIMEOUT_EN) begin
                    if (wait_cnt_q == WAIT_LAST) begin
                        wait_cnt_d   = '0;
                        turn_done_d  = 1'b1;
                        cur_player_d = next_player;
                    end else begin
                        wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                    end
                end
            end
            ST_MOVE: begin
                if (step_tick) begin
                    positions_d[pos_base +: POS_W] = next_pos;
                    if (next_pos == LAST_CELL) begin
                        winner_d    = cur_player_q;
                        timer_abort = 1'b1;
                        state_d     = ST_GAME_OVER;
                    end else if (step_done) begin
                        state_d = ST_WAIT_CLEAR;
                    end
                end
            end
            ST_WAIT_CLEAR: begin
                if (turn_end) begin
                    turn_done_d  = 1'b1;
                    cur_player_d = next_player;
                    wait_cnt_d   = '0;
                    state_d      = ST_WAIT_COLOR;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        move_active_d = (state_d == ST_MOVE);
        game_over_d   = (state_d == ST_GAME_OVER);
    end

    // Game state registers; reset aborts any move in progress.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            cur_player_q  <= '0;
            positions_q   <= '0;
            winner_q      <= '0;
            turn_done_q   <= 1'b0;
            move_active_q <= 1'b0;
            game_over_q   <= 1'b0;
            wait_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            cur_player_q  <= cur_player_d;
            positions_q   <= positions_d;
            winner_q      <= winner_d;
            turn_done_q   <= turn_done_d;
            move_active_q <= move_active_d;
            game_over_q   <= game_over_d;
            wait_cnt_q    <= wait_cnt_d;
        end
    end

    assign cur_player  = cur_player_q;
    assign positions   = positions_q;
    assign state_o     = state_q;
    assign move_active = move_active_q;
    assign turn_done   = turn_done_q;
    assign winner      = winner_q;
    assign game_over   = game_over_q;

endmodule

// File: tb/tb_dice_turn_controller.sv
// Directed bench for dice_turn_controller (STEP_TICKS=4, BOARD_LEN=6,
// two players); a second instance has a 10-cycle colour timeout.
module tb_dice_turn_controller;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic [1:0] detected_color = 2'b00;
    logic       color_result_ready = 1'b0;
    logic       turn_end = 1'b0;

    logic       cur_player, cur_player2;
    logic [5:0] positions, positions2;
    logic [2:0] state_o, state2;
    logic       move_active, move_active2;
    logic       turn_done, turn_done2;
    logic       winner, winner2;
    logic       game_over, game_over2;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    dice_turn_controller #(
        .NUM_PLAYERS(2), .BOARD_LEN(6), .POS_W(3),
        .RED_STEPS(1), .GREEN_STEPS(2), .BLUE_STEPS(3),
        .STEP_TICKS(4), .TIMEOUT_TICKS(0)
    ) dut (
        .clk(clk), .reset(reset), .start(start),
        .detected_color(detected_color),
        .color_result_ready(color_result_ready),
        .turn_end(turn_end), .cur_player(cur_player),
        .positions(positions), .state_o(state_o),
        .move_active(move_active), .turn_done(turn_done),
        .winner(winner), .game_over(game_over)
    );

    dice_turn_controller #(
        .NUM_PLAYERS(2), .BOARD_LEN(6), .POS_W(3),
        .RED_STEPS(1), .GREEN_STEPS(2), .BLUE_STEPS(3),
        .STEP_TICKS(4), .TIMEOUT_TICKS(10)
    ) dut_to (
        .clk(clk), .reset(reset), .start(start),
        .detected_color(detected_color),
        .color_result_ready(color_result_ready),
        .turn_end(turn_end), .cur_player(cur_player2),
        .positions(positions2), .state_o(state2),
        .move_active(move_active2), .turn_done(turn_done2),
        .winner(winner2), .game_over(game_over2)
    );

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic pulse_color(input logic [1:0] c, input logic te);
        detected_color = c;
        color_result_ready = 1'b1;
        turn_end = te;
        @(negedge clk);
        color_result_ready = 1'b0;
        turn_end = 1'b0;
        detected_color = 2'b00;
    endtask

    task automatic pulse_turn_end();
        turn_end = 1'b1;
        @(negedge clk);
        turn_end = 1'b0;
    endtask

    task automatic test_reset();
        wait_neg(2);
        checks++; if (state_o !== 3'd0) $display("FAIL rst_state: got %0d want 0", state_o); else passed++;
        checks++; if (positions !== 6'd0) $display("FAIL rst_pos: got %0h want 0", positions); else passed++;
        checks++; if (cur_player !== 1'b0) $display("FAIL rst_cur: got %0d want 0", cur_player); else passed++;
        checks++; if ({move_active, turn_done, winner, game_over} !== 4'b0)
            $display("FAIL rst_flags: got %b want 0000", {move_active, turn_done, winner, game_over}); else passed++;
        reset = 1'b1;
        wait_neg(1);
        checks++; if (state_o !== 3'd0) $display("FAIL idle_hold: got %0d want 0", state_o); else passed++;
        pulse_start();
        checks++; if (state_o !== 3'd1) $display("FAIL start_state: got %0d want 1", state_o); else passed++;
        checks++; if (positions !== 6'd0) $display("FAIL start_pos: got %0h want 0", positions); else passed++;
        checks++; if (cur_player !== 1'b0) $display("FAIL start_cur: got %0d want 0", cur_player); else passed++;
    endtask

    task automatic test_green_move();
        pulse_color(2'b10, 1'b0);
        checks++; if (state_o !== 3'd2) $display("FAIL g_move_state: got %0d want 2", state_o); else passed++;
        checks++; if (move_active !== 1'b1) $display("FAIL g_move_active: got %b want 1", move_active); else passed++;
        wait_neg(3);
        checks++; if (positions[2:0] !== 3'd0) $display("FAIL g_pos_t3: got %0d want 0", positions[2:0]); else passed++;
        wait_neg(1);
        checks++; if (positions[2:0] !== 3'd1) $display("FAIL g_pos_t4: got %0d want 1", positions[2:0]); else passed++;
        wait_neg(3);
        checks++; if (state_o !== 3'd2) $display("FAIL g_state_t7: got %0d want 2", state_o); else passed++;
        wait_neg(1);
        checks++; if (state_o !== 3'd3) $display("FAIL g_state_t8: got %0d want 3", state_o); else passed++;
        checks++; if (positions !== 6'b000_010) $display("FAIL g_pos_t8: got %0h want 02", positions); else passed++;
        checks++; if (move_active !== 1'b0) $display("FAIL g_ma_t8: got %b want 0", move_active); else passed++;
        pulse_turn_end();
        checks++; if (turn_done !== 1'b1) $display("FAIL g_td: got %b want 1", turn_done); else passed++;
        checks++; if (cur_player !== 1'b1) $display("FAIL g_cur: got %0d want 1", cur_player); else passed++;
        checks++; if (state_o !== 3'd1) $display("FAIL g_back_wait: got %0d want 1", state_o); else passed++;
        wait_neg(1);
        checks++; if (turn_done !== 1'b0) $display("FAIL g_td_single: got %b want 0", turn_done); else passed++;
    endtask

    task automatic test_none_and_simultaneous();
        pulse_color(2'b00, 1'b0);
        checks++; if (state_o !== 3'd1) $display("FAIL none_ignored: got %0d want 1", state_o); else passed++;
        pulse_turn_end();
        checks++; if (state_o !== 3'd1) $display("FAIL te_in_wait: got %0d want 1", state_o); else passed++;
        checks++; if (turn_done !== 1'b0) $display("FAIL te_in_wait_td: got %b want 0", turn_done); else passed++;
        pulse_color(2'b11, 1'b1);
        checks++; if (state_o !== 3'd2) $display("FAIL sim_state: got %0d want 2", state_o); else passed++;
        checks++; if (turn_done !== 1'b0) $display("FAIL sim_td: got %b want 0", turn_done); else passed++;
        wait_neg(11);
        checks++; if (state_o !== 3'd2) $display("FAIL b_state_t11: got %0d want 2", state_o); else passed++;
        checks++; if (positions[5:3] !== 3'd2) $display("FAIL b_pos_t11: got %0d want 2", positions[5:3]); else passed++;
        wait_neg(1);
        checks++; if (state_o !== 3'd3) $display("FAIL b_state_t12: got %0d want 3", state_o); else passed++;
        checks++; if (positions !== 6'b011_010) $display("FAIL b_pos_t12: got %0h want 1a", positions); else passed++;
        pulse_color(2'b01, 1'b0);
        checks++; if (state_o !== 3'd3) $display("FAIL clr_ignores_color: got %0d want 3", state_o); else passed++;
    endtask

    task automatic test_game_over();
        pulse_turn_end();
        checks++; if (cur_player !== 1'b0) $display("FAIL go_cur0: got %0d want 0", cur_player); else passed++;
        pulse_color(2'b01, 1'b0);
        wait_neg(4);
        checks++; if (positions !== 6'b011_011) $display("FAIL go_pos_a: got %0h want 1b", positions); else passed++;
        checks++; if (state_o !== 3'd3) $display("FAIL go_state_a: got %0d want 3", state_o); else passed++;
        pulse_turn_end();
        pulse_color(2'b01, 1'b0);
        wait_neg(4);
        checks++; if (positions !== 6'b100_011) $display("FAIL go_pos_b: got %0h want 23", positions); else passed++;
        pulse_turn_end();
        pulse_color(2'b01, 1'b0);
        wait_neg(4);
        checks++; if (positions !== 6'b100_100) $display("FAIL go_pos_c: got %0h want 24", positions); else passed++;
        pulse_turn_end();
        checks++; if (cur_player !== 1'b1) $display("FAIL go_cur1: got %0d want 1", cur_player); else passed++;
        pulse_color(2'b11, 1'b0);
        wait_neg(3);
        checks++; if (state_o !== 3'd2) $display("FAIL win_state_t3: got %0d want 2", state_o); else passed++;
        wait_neg(1);
        checks++; if (state_o !== 3'd4) $display("FAIL win_state: got %0d want 4", state_o); else passed++;
        checks++; if (game_over !== 1'b1) $display("FAIL win_go: got %b want 1", game_over); else passed++;
        checks++; if (winner !== 1'b1) $display("FAIL win_who: got %0d want 1", winner); else passed++;
        checks++; if (positions !== 6'b101_100) $display("FAIL win_pos: got %0h want 2c", positions); else passed++;
        checks++; if (move_active !== 1'b0) $display("FAIL win_ma: got %b want 0", move_active); else passed++;
        wait_neg(8);
        checks++; if (positions !== 6'b101_100) $display("FAIL win_clamp: got %0h want 2c", positions); else passed++;
        pulse_color(2'b10, 1'b1);
        checks++; if (state_o !== 3'd4) $display("FAIL go_ignores: got %0d want 4", state_o); else passed++;
        pulse_start();
        checks++; if (state_o !== 3'd1) $display("FAIL restart_state: got %0d want 1", state_o); else passed++;
        checks++; if (positions !== 6'd0) $display("FAIL restart_pos: got %0h want 0", positions); else passed++;
        checks++; if (cur_player !== 1'b0) $display("FAIL restart_cur: got %0d want 0", cur_player); else passed++;
        checks++; if (game_over !== 1'b0) $display("FAIL restart_go: got %b want 0", game_over); else passed++;
    endtask

    task automatic test_timeout();
        reset = 1'b0;
        wait_neg(2);
        reset = 1'b1;
        wait_neg(1);
        pulse_start();
        checks++; if (state2 !== 3'd1) $display("FAIL to_start: got %0d want 1", state2); else passed++;
        wait_neg(9);
        checks++; if (turn_done2 !== 1'b0) $display("FAIL to_early: got %b want 0", turn_done2); else passed++;
        wait_neg(1);
        checks++; if (turn_done2 !== 1'b1) $display("FAIL to_pulse1: got %b want 1", turn_done2); else passed++;
        checks++; if (cur_player2 !== 1'b1) $display("FAIL to_cur1: got %0d want 1", cur_player2); else passed++;
        checks++; if (state2 !== 3'd1) $display("FAIL to_state: got %0d want 1", state2); else passed++;
        checks++; if ({positions2, move_active2, winner2, game_over2} !== 9'd0)
            $display("FAIL to_nomove: got %b want 0", {positions2, move_active2, winner2, game_over2}); else passed++;
        checks++; if (turn_done !== 1'b0) $display("FAIL no_to_main: got %b want 0", turn_done); else passed++;
        wait_neg(1);
        checks++; if (turn_done2 !== 1'b0) $display("FAIL to_single: got %b want 0", turn_done2); else passed++;
        wait_neg(9);
        checks++; if (turn_done2 !== 1'b1) $display("FAIL to_pulse2: got %b want 1", turn_done2); else passed++;
        checks++; if (cur_player2 !== 1'b0) $display("FAIL to_wrap: got %0d want 0", cur_player2); else passed++;
    endtask

    task automatic test_reset_mid_move();
        pulse_color(2'b10, 1'b0);
        wait_neg(5);
        checks++; if (positions[2:0] !== 3'd1) $display("FAIL mid_pos: got %0d want 1", positions[2:0]); else passed++;
        #2 reset = 1'b0;
        #1;
        checks++; if (state_o !== 3'd0) $display("FAIL async_state: got %0d want 0", state_o); else passed++;
        checks++; if (positions !== 6'd0) $display("FAIL async_pos: got %0h want 0", positions); else passed++;
        checks++; if (move_active !== 1'b0) $display("FAIL async_ma: got %b want 0", move_active); else passed++;
        @(negedge clk);
        reset = 1'b1;
        wait_neg(2);
        checks++; if (state_o !== 3'd0) $display("FAIL post_rst_idle: got %0d want 0", state_o); else passed++;
        checks++; if (positions !== 6'd0) $display("FAIL post_rst_pos: got %0h want 0", positions); else passed++;
    endtask

    initial begin
        test_reset();
        test_green_move();
        test_none_and_simultaneous();
        test_game_over();
        test_timeout();
        test_reset_mid_move();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
